// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the execute-stage ALU.
package alu_pkg;

   localparam int ALU_WIDTH = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/result bus between the execute stage and the ALU.
// Handshake: the master raises en for exactly the cycles whose operands are
// valid; the ALU always accepts (no ready, no backpressure) and raises
// out_valid for the single cycle following each accepted edge.
interface alu_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);
   logic             en;
   logic [1:0]       operation;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] out;
   logic             flag;
   logic             zero;
   logic             sign;
   logic             out_valid;

   modport master (
      output en, operation, a, b,
      input  out, flag, zero, sign, out_valid
   );

   modport slave (
      input  en, operation, a, b,
      output out, flag, zero, sign, out_valid
   );
endinterface : alu_if

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sub computes a + ~b + 1 on the same adder, carry-out
// dropped, with signed overflow detection.
module alu_addsub #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] cin_ext;

   // Invert B and inject a carry-in of one for subtraction.
   always_comb begin
      b_eff   = sub_i ? ~b_i : b_i;
      cin_ext = {{(WIDTH-1){1'b0}}, sub_i};
      sum_o   = a_i + b_eff + cin_ext;
      // Overflow when the effective addends share a sign that the sum does not.
      // For sub this is a[msb] != b[msb] && r[msb] != a[msb].
      ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
   end

endmodule : alu_addsub

// File: rtl/alu_64.sv
// Y86-64 execute-stage ALU: add/sub/and/xor with one-cycle registered result
// and condition flags (overflow, zero, sign).
module alu_64
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic clk,
   input  logic rst,
   alu_if.slave bus
);

   logic [WIDTH-1:0] sum;
   logic             ovf;
   logic             is_sub;

   logic [WIDTH-1:0] r;
   logic             r_flag;

   logic [WIDTH-1:0] out_d, out_q;
   logic             flag_d, flag_q;
   logic             zero_d, zero_q;
   logic             sign_d, sign_q;
   logic             valid_d, valid_q;

   assign is_sub = (bus.operation == ALU_SUB);

   alu_addsub #(
      .WIDTH (WIDTH)
   ) u_addsub (
      .a_i   (bus.a),
      .b_i   (bus.b),
      .sub_i (is_sub),
      .sum_o (sum),
      .ovf_o (ovf)
   );

   // Result mux; overflow only meaningful for the arithmetic ops.
   always_comb begin
      r      = sum;
      r_flag = 1'b0;
      unique case (bus.operation)
         ALU_ADD, ALU_SUB: begin
            r      = sum;
            r_flag = ovf;
         end
         ALU_AND: r = bus.a & bus.b;
         ALU_XOR: r = bus.a ^ bus.b;
         default: r = sum;
      endcase
   end

   // Next-state: capture on en, otherwise hold result/flags and drop valid.
   always_comb begin
      out_d   = out_q;
      flag_d  = flag_q;
      zero_d  = zero_q;
      sign_d  = sign_q;
      valid_d = 1'b0;
      if (bus.en) begin
         out_d   = r;
         flag_d  = r_flag;
         zero_d  = (r == '0);
         sign_d  = r[WIDTH-1];
         valid_d = 1'b1;
      end
   end

   // Output registers, cleared asynchronously so reset takes effect without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         flag_q  <= 1'b0;
         zero_q  <= 1'b0;
         sign_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         flag_q  <= flag_d;
         zero_q  <= zero_d;
         sign_q  <= sign_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.flag      = flag_q;
   assign bus.zero      = zero_q;
   assign bus.sign      = sign_q;
   assign bus.out_valid = valid_q;

endmodule : alu_64

// File: tb/tb_alu_64.sv
// Directed test of alu_64: arithmetic/logic results, overflow boundaries,
// hold behaviour with en low, and asynchronous reset.
module tb_alu_64;
   import alu_pkg::*;

   localparam int W = 64;
   localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

   logic clk;
   logic rst;
   int   total;
   int   bad;

   alu_if #(.WIDTH(W)) bus ();

   alu_64 #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Full result check: zero/sign expectations follow from the expected value.
   task automatic check_res(input string tag, input logic [W-1:0] exp_out, input logic exp_flag);
      logic [W-1:0] e;
      e = exp_out;
      check({tag, ".out"},   bus.out, e);
      check({tag, ".flag"},  {{(W-1){1'b0}}, bus.flag},      {{(W-1){1'b0}}, exp_flag});
      check({tag, ".zero"},  {{(W-1){1'b0}}, bus.zero},      {{(W-1){1'b0}}, (e == '0)});
      check({tag, ".sign"},  {{(W-1){1'b0}}, bus.sign},      {{(W-1){1'b0}}, e[W-1]});
      check({tag, ".valid"}, {{(W-1){1'b0}}, bus.out_valid}, {{(W-1){1'b0}}, 1'b1});
   endtask

   task automatic check_zero_all(input string tag);
      check({tag, ".out"},   bus.out, '0);
      check({tag, ".flag"},  {{(W-1){1'b0}}, bus.flag},      '0);
      check({tag, ".zero"},  {{(W-1){1'b0}}, bus.zero},      '0);
      check({tag, ".sign"},  {{(W-1){1'b0}}, bus.sign},      '0);
      check({tag, ".valid"}, {{(W-1){1'b0}}, bus.out_valid}, '0);
   endtask

   // Driver: present operands with en=1 at the falling edge, sample #1 after rising edge.
   task automatic apply(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      bus.en        = 1'b1;
      bus.operation = op;
      bus.a         = av;
      bus.b         = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.en        = 1'b0;
      bus.operation = 2'b00;
      bus.a         = '0;
      bus.b         = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst           = 1'b1;
      bus.en        = 1'b0;
      bus.operation = 2'b00;
      bus.a         = '0;
      bus.b         = '0;

      // Reset state before any clock edge.
      #1;
      check_zero_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1. add 5+7
      apply(ALU_ADD, 64'd5, 64'd7);
      check_res("add_5_7", 64'd12, 1'b0);
      // 2. MAX+1 wraps to MIN
      apply(ALU_ADD, MAX_V, 64'd1);
      check_res("add_max_1", 64'h8000_0000_0000_0000, 1'b1);
      // -1 + -1 = -2, no overflow
      apply(ALU_ADD, '1, '1);
      check_res("add_m1_m1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      // 3. sub 3-5
      apply(ALU_SUB, 64'd3, 64'd5);
      check_res("sub_3_5", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      // MIN-1 wraps to MAX
      apply(ALU_SUB, MIN_V, 64'd1);
      check_res("sub_min_1", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      // 0-MIN = MIN
      apply(ALU_SUB, 64'd0, MIN_V);
      check_res("sub_0_min", 64'h8000_0000_0000_0000, 1'b1);
      // a-a = 0
      apply(ALU_SUB, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
      check_res("sub_a_a", 64'd0, 1'b0);
      // 4. and / xor
      apply(ALU_AND, 64'hF0F0, 64'hFF00);
      check_res("and", 64'hF000, 1'b0);
      apply(ALU_XOR, 64'h1234, 64'h1234);
      check_res("xor_same", 64'd0, 1'b0);
      // and with operands that would overflow as an add: flag stays 0
      apply(ALU_AND, MAX_V, MAX_V);
      check_res("and_max", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      apply(ALU_XOR, MIN_V, 64'd1);
      check_res("xor_min", 64'h8000_0000_0000_0001, 1'b0);

      // 5. back-to-back then hold
      apply(ALU_ADD, 64'd10, 64'd20);
      check_res("b2b_0", 64'd30, 1'b0);
      apply(ALU_SUB, 64'd100, 64'd1);
      check_res("b2b_1", 64'd99, 1'b0);
      apply(ALU_XOR, 64'hFF, 64'h0F);
      check_res("b2b_2", 64'hF0, 1'b0);
      idle();
      check("hold0.valid", {{(W-1){1'b0}}, bus.out_valid}, '0);
      check("hold0.out", bus.out, 64'hF0);
      idle();
      check("hold1.valid", {{(W-1){1'b0}}, bus.out_valid}, '0);
      check("hold1.out", bus.out, 64'hF0);
      check("hold1.sign", {{(W-1){1'b0}}, bus.sign}, '0);

      // 6. async reset between edges after a result with nonzero flags
      apply(ALU_ADD, MAX_V, 64'd1);
      check_res("pre_rst", 64'h8000_0000_0000_0000, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero_all("async_rst");
      // an op presented during reset is discarded
      bus.en        = 1'b1;
      bus.operation = ALU_ADD;
      bus.a         = 64'd7;
      bus.b         = 64'd7;
      @(posedge clk);
      #1;
      check_zero_all("rst_inflight");
      @(negedge clk);
      bus.en = 1'b0;
      rst    = 1'b0;
      @(posedge clk);
      #1;
      check_zero_all("post_release_idle");
      apply(ALU_ADD, 64'd1, 64'd1);
      check_res("add_1_1", 64'd2, 1'b0);
      idle();
      check("final.valid", {{(W-1){1'b0}}, bus.out_valid}, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_alu_64
